// File: rtl/ft232h_pkg.sv
// Shared constants and types for the FT232H synchronous-245 write path.
//   FT232H_DATA_WIDTH : width of the FT232H data bus and of the AXIS byte stream
//   ft232h_state_t    : holding-register state (IDLE / HOLD / WRITE)
package ft232h_pkg;

  localparam int unsigned FT232H_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // holding register empty
    HOLD  = 2'd1,  // byte held, FT232H TX FIFO full
    WRITE = 2'd2   // byte held, FT232H accepts it this edge
  } ft232h_state_t;

endpackage

// File: rtl/axis_io.sv
// Minimal AXI-Stream byte interface.
//   clk, rst      : clock/reset of the stream (carry ftdi_clk/rst here)
//   tdata, tvalid : source -> sink beat
//   tready        : sink -> source backpressure
interface axis_io;
  import ft232h_pkg::*;

  logic                         clk;
  logic                         rst;
  logic [FT232H_DATA_WIDTH-1:0] tdata;
  logic                         tvalid;
  logic                         tready;

  modport Sink   (input clk, input rst, input tdata, input tvalid, output tready);
  modport Source (input clk, input rst, output tdata, output tvalid, input tready);
endinterface

// File: rtl/ft232h_tx_reg.sv
// One-byte holding register between an AXIS byte stream and the FT232H bus.
//   clk_i, rst_i : clock, synchronous active-high reset
//   tdata_i      : AXIS byte in
//   tvalid_i     : AXIS beat valid
//   tready_o     : AXIS ready (register empty, or draining this edge)
//   txe_n_i      : low = FT232H TX FIFO accepts a byte this edge
//   wr_n_o       : FT232H write strobe, active low
//   data_o       : held byte (drives the bus)
//   state_o      : decoded holding-register state
module ft232h_tx_reg
  import ft232h_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [FT232H_DATA_WIDTH-1:0] tdata_i,
  input  logic                         tvalid_i,
  output logic                         tready_o,
  input  logic                         txe_n_i,
  output logic                         wr_n_o,
  output logic [FT232H_DATA_WIDTH-1:0] data_o,
  output ft232h_state_t                state_o
);

  logic [FT232H_DATA_WIDTH-1:0] data_q, data_d;
  logic                         valid_q, valid_d;
  ft232h_state_t                state;

  // HOLD vs WRITE depends on the live txe_n, so the state is a decode of
  // valid_q and txe_n rather than a separate register.
  always_comb begin
    state = IDLE;
    if (valid_q) state = txe_n_i ? HOLD : WRITE;
  end

  // Reset masks the handshake and the strobe so a held byte is never written
  // and no beat is accepted while rst is high.
  assign tready_o = !rst_i && (state != HOLD);
  assign wr_n_o   = !(!rst_i && (state == WRITE));

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (tvalid_i && tready_o) begin
      data_d  = tdata_i;
      valid_d = 1'b1;
    end else if (state == WRITE) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign state_o = state;

endmodule

// File: rtl/ft232h.sv
// FT232H synchronous-245 FIFO bridge, write-only (FPGA -> PC).
//   ftdi_clk    : 60 MHz CLKOUT from the FT232H, sole clock
//   rst         : synchronous active-high reset
//   ftdi_rxf_n  : PC data available, ignored by this write-only bridge
//   ftdi_txe_n  : low = FT232H TX FIFO can accept a byte
//   ftdi_rd_n   : read strobe, tied inactive
//   ftdi_wr_n   : write strobe, active low
//   ftdi_siwu_n : send-immediate/wake-up, tied inactive
//   ftdi_oe_n   : FT232H output enable, tied inactive (FPGA owns the bus)
//   ftdi_adbus  : data bus, always driven with the held byte
//   sys_axis    : AXIS byte stream sink
module ft232h
  import ft232h_pkg::*;
(
  input  logic                              ftdi_clk,
  input  logic                              rst,
  input  logic                              ftdi_rxf_n,
  input  logic                              ftdi_txe_n,
  output logic                              ftdi_rd_n,
  output logic                              ftdi_wr_n,
  output logic                              ftdi_siwu_n,
  output logic                              ftdi_oe_n,
  inout  wire  [FT232H_DATA_WIDTH-1:0]      ftdi_adbus,
  axis_io.Sink                              sys_axis
);

  logic [FT232H_DATA_WIDTH-1:0] data;
  ft232h_state_t                state;
  logic                         unused_ok;

  ft232h_tx_reg u_tx_reg (
    .clk_i    (ftdi_clk),
    .rst_i    (rst),
    .tdata_i  (sys_axis.tdata),
    .tvalid_i (sys_axis.tvalid),
    .tready_o (sys_axis.tready),
    .txe_n_i  (ftdi_txe_n),
    .wr_n_o   (ftdi_wr_n),
    .data_o   (data),
    .state_o  (state)
  );

  assign ftdi_rd_n   = 1'b1;
  assign ftdi_siwu_n = 1'b1;
  assign ftdi_oe_n   = 1'b1;
  assign ftdi_adbus  = data;

  assign unused_ok = ^{ftdi_rxf_n, sys_axis.clk, sys_axis.rst, state};

endmodule

// File: tb/tb_ft232h.sv
module tb_ft232h;
  import ft232h_pkg::*;

  logic       clk = 1'b0;
  logic       rst, txe_n, rxf_n, tvalid;
  logic [7:0] tdata;
  logic       rd_n, wr_n, siwu_n, oe_n;
  wire  [7:0] adbus;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  pc_q[$];   // bytes seen by the FT232H model (PC-side FIFO)

  axis_io sys_axis();
  assign sys_axis.clk    = clk;
  assign sys_axis.rst    = rst;
  assign sys_axis.tdata  = tdata;
  assign sys_axis.tvalid = tvalid;

  ft232h dut (
    .ftdi_clk    (clk),
    .rst         (rst),
    .ftdi_rxf_n  (rxf_n),
    .ftdi_txe_n  (txe_n),
    .ftdi_rd_n   (rd_n),
    .ftdi_wr_n   (wr_n),
    .ftdi_siwu_n (siwu_n),
    .ftdi_oe_n   (oe_n),
    .ftdi_adbus  (adbus),
    .sys_axis    (sys_axis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, txe_n, rxf_n, tvalid;
    logic [7:0] tdata;
    logic       exp_tready, exp_wr_n;
    logic [7:0] exp_ad;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge; the FT232H model captures the bus for
  // the coming rising edge whenever wr_n is low.
  task automatic drive(input logic r, input logic txe, input logic rxf,
                       input logic tv, input logic [7:0] td);
    @(negedge clk);
    rst = r; txe_n = txe; rxf_n = rxf; tvalid = tv; tdata = td;
    #1;
    if (!wr_n) pc_q.push_back(adbus);
  endtask

  task automatic chk_pc(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, pc_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < pc_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), pc_q[i], exp[i]);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int unsigned nxt;
    bit done;

    rst = 1'b1; txe_n = 1'b0; rxf_n = 1'b1; tvalid = 1'b0; tdata = '0;
    drive(1, 0, 1, 0, 8'd0);

    //          rst txe rxf tv  td      trdy wr_n ad
    vecs[0]  = '{1, 0, 1, 1, 8'd5,   0, 1, 8'd0};
    vecs[1]  = '{0, 0, 1, 1, 8'd69,  1, 1, 8'd0};
    vecs[2]  = '{0, 0, 1, 1, 8'd70,  1, 0, 8'd69};
    vecs[3]  = '{0, 0, 0, 1, 8'd71,  1, 0, 8'd70};
    vecs[4]  = '{0, 1, 0, 1, 8'd72,  0, 1, 8'd71};
    vecs[5]  = '{0, 1, 1, 1, 8'd72,  0, 1, 8'd71};
    vecs[6]  = '{0, 0, 1, 1, 8'd72,  1, 0, 8'd71};
    vecs[7]  = '{0, 0, 0, 0, 8'd0,   1, 0, 8'd72};
    vecs[8]  = '{0, 0, 1, 0, 8'd0,   1, 1, 8'd72};
    vecs[9]  = '{0, 1, 1, 1, 8'd73,  1, 1, 8'd72};
    vecs[10] = '{0, 1, 0, 1, 8'd74,  0, 1, 8'd73};
    vecs[11] = '{1, 0, 1, 1, 8'd74,  0, 1, 8'd73};
    vecs[12] = '{0, 0, 0, 1, 8'd100, 1, 1, 8'd0};
    vecs[13] = '{0, 0, 0, 0, 8'd0,   1, 0, 8'd100};
    vecs[14] = '{0, 0, 1, 0, 8'd0,   1, 1, 8'd100};

    pc_q.delete();
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].txe_n, vecs[i].rxf_n, vecs[i].tvalid, vecs[i].tdata);
      chk($sformatf("v%0d_tready", i), sys_axis.tready, vecs[i].exp_tready);
      chk($sformatf("v%0d_wr_n", i), wr_n, vecs[i].exp_wr_n);
      chk($sformatf("v%0d_adbus", i), adbus, vecs[i].exp_ad);
      chk($sformatf("v%0d_ties", i), {rd_n, oe_n, siwu_n}, 3'b111);
    end
    exp_q = '{8'd69, 8'd70, 8'd71, 8'd72, 8'd100};
    chk_pc("table_stream", exp_q);

    // Stall: 69 held while TX FIFO is full, then written exactly once.
    drive(1, 0, 1, 0, 8'd0);
    pc_q.delete();
    drive(0, 1, 1, 1, 8'd69);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 1, 8'd99);
      chk($sformatf("stall%0d_wr_n", i), wr_n, 1);
      chk($sformatf("stall%0d_adbus", i), adbus, 69);
      chk($sformatf("stall%0d_tready", i), sys_axis.tready, 0);
    end
    drive(0, 0, 1, 0, 8'd0);
    chk("stall_release_wr_n", wr_n, 0);
    drive(0, 0, 1, 0, 8'd0);
    chk("stall_after_wr_n", wr_n, 1);
    drive(0, 0, 1, 0, 8'd0);
    exp_q = '{8'd69};
    chk_pc("stall_stream", exp_q);

    // Burst 69..78 with the TX FIFO going full mid-burst and rxf_n held low.
    pc_q.delete();
    nxt = 69;
    done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      logic txe, tv;
      txe = (cyc == 3 || cyc == 4 || cyc == 7 || cyc == 8 || cyc == 9);
      tv  = (nxt <= 78);
      drive(0, txe, 0, tv, 8'(nxt));
      if ({rd_n, oe_n, siwu_n} !== 3'b111) chk("burst_ties", {rd_n, oe_n, siwu_n}, 3'b111);
      if (tv && sys_axis.tready) nxt++;
      else if (!tv && !txe && wr_n) done = 1;
    end
    chk("burst_done", done, 1);
    exp_q.delete();
    for (int b = 69; b <= 78; b++) exp_q.push_back(8'(b));
    chk_pc("burst_stream", exp_q);

    // tvalid dropped after three beats: strobe stops after the third write.
    pc_q.delete();
    drive(0, 0, 1, 1, 8'd69);
    drive(0, 0, 1, 1, 8'd70);
    drive(0, 0, 1, 1, 8'd71);
    drive(0, 0, 1, 0, 8'd0);
    chk("drop_third_wr_n", wr_n, 0);
    chk("drop_third_adbus", adbus, 71);
    drive(0, 0, 1, 0, 8'd0);
    chk("drop_idle_wr_n", wr_n, 1);
    exp_q = '{8'd69, 8'd70, 8'd71};
    chk_pc("drop_stream", exp_q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ft232h.md
FT232H -- requirements
Module: ft232h

Interface
REQ-001 No parameters; byte width fixed at 8 via shared package constant.
REQ-002 ftdi_clk  in  1  sole clock (60 MHz from FT232H CLKOUT); all logic and sys_axis are synchronous to it.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on ftdi_clk rising edge.
REQ-004 ftdi_rxf_n  in  1  low = PC has data for FPGA (ignored by this block).
REQ-005 ftdi_txe_n  in  1  low = FT232H TX FIFO can accept a byte this edge.
REQ-006 ftdi_rd_n  out  1  read strobe, active low.
REQ-007 ftdi_wr_n  out  1  write strobe, active low.
REQ-008 ftdi_siwu_n  out  1  send-immediate/wake-up, active low.
REQ-009 ftdi_oe_n  out  1  FT232H bus output enable, active low.
REQ-010 ftdi_adbus  inout  8  bidirectional data bus.
REQ-011 sys_axis  axis_io.Sink  8-bit tdata, tvalid, tready  byte stream FPGA->PC; clk/rst members carry ftdi_clk/rst.

Function
REQ-012 Synchronous 245 FIFO mode, write-only: ftdi_rd_n=1, ftdi_oe_n=1, ftdi_siwu_n=1 constantly.
REQ-013 ftdi_adbus driven by FPGA at all times (ftdi_oe_n high), value = holding register data_q.
REQ-014 One-byte holding register {data_q, valid_q} between sys_axis and bus.
REQ-015 sys_axis.tready = !valid_q || !ftdi_txe_n (combinational; register empty or draining this edge).
REQ-016 ftdi_wr_n = !(valid_q && !ftdi_txe_n), combinational; byte counts as written at every rising edge with ftdi_wr_n low.
REQ-017 On edge with tvalid && tready: data_q <= tdata, valid_q <= 1; else if byte written: valid_q <= 0; else hold.
REQ-018 Latency: beat accepted at edge N appears on ftdi_adbus after N, written at edge N+1 if ftdi_txe_n low.
REQ-019 Throughput: one byte per ftdi_clk while tvalid high and ftdi_txe_n low; no bubbles.
REQ-020 ftdi_txe_n high: ftdi_wr_n high, data_q/valid_q held, tready = !valid_q; no byte lost or duplicated.
REQ-021 ftdi_txe_n rising mid-burst: current byte stays in data_q and is written at first edge with ftdi_txe_n low.
REQ-022 Bytes reach the FT232H in exact AXIS acceptance order.
REQ-023 State (ft232h_state_t): IDLE (valid_q=0), HOLD (valid_q=1, txe_n high), WRITE (valid_q=1, txe_n low); transitions per REQ-017.

Reset
REQ-024 During rst: valid_q=0, data_q=0, state IDLE; ftdi_wr_n=1, ftdi_rd_n=1, ftdi_oe_n=1, ftdi_siwu_n=1, ftdi_adbus=0, tready=0.
REQ-025 Reset mid-transfer discards held byte; first edge after rst release is IDLE, tready=1.

Structure
REQ-026 Package ft232h_pkg holds FT232H_DATA_WIDTH=8 and ft232h_state_t.
REQ-027 Holding register is sub-module ft232h_tx_reg; ft232h instantiates it and does pin mapping/tie-offs.
REQ-028 Verification uses ft232h_bfm (FT232H model with PC-side AXIS tdata/tvalid/tready output FIFO) and axis_io interface.

Verification
REQ-029 Burst: txe_n low, tvalid held, tdata 69,70,71... -> ftdi_adbus 69,70,71 on consecutive wr_n-low edges; BFM PC side outputs same sequence.
REQ-030 Stall: valid_q=1 holding 69, txe_n high 5 cycles -> wr_n high, adbus=69 stable, tready=0; txe_n low -> 69 written once.
REQ-031 BFM TX FIFO full mid-burst of 69..78 -> PC side outputs 69..78 with no gaps or duplicates.
REQ-032 rst asserted with valid_q=1 -> wr_n=1, tready=0 during rst; after release, next beat 100 written first, old byte never.
REQ-033 rxf_n toggled low throughout -> rd_n, oe_n, siwu_n stay 1; write stream unaffected.
REQ-034 tvalid dropped after 3 beats 69..71 -> wr_n rises after third write; pc_tvalid falls once BFM drained.
